// File: rtl/mmio_console.sv
// Memory-mapped console: a done/exit register and a print register feeding a byte FIFO.
// Writes to the print register stall only when the FIFO is full; reads answer one cycle later.
module mmio_console #(
  parameter int                XLEN       = 32,
  parameter logic [XLEN-1:0]   DONE_ADDR  = 32'h0000_0100,
  parameter logic [XLEN-1:0]   PRINT_ADDR = 32'h0000_0104,
  parameter int                FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [XLEN/8-1:0] req_wstrb,
  output logic              hit,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              char_valid,
  input  logic              char_ready,
  output logic [7:0]        char_data,
  output logic              done,
  output logic [XLEN-1:0]   exit_code
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] exit_q, exit_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic is_done, is_print, accept, push, pop;
  logic unused_strb;

  assign unused_strb = ^req_wstrb[XLEN/8-1:1];

  assign is_done  = (req_addr == DONE_ADDR);
  assign is_print = (req_addr == PRINT_ADDR);
  assign hit      = is_done | is_print;

  // Ready looks only at the registered count, so a same-cycle pop never opens a slot.
  assign req_ready = !(req_valid && req_we && is_print && (count_q == FULL_CNT));
  assign accept    = req_valid && req_ready;
  assign push      = accept && req_we && is_print && req_wstrb[0];

  assign char_valid = (count_q != '0);
  assign char_data  = mem_q[rd_ptr_q];
  assign pop        = char_valid && char_ready;

  assign done      = done_q;
  assign exit_code = exit_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

  always_comb begin
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    done_d      = done_q;
    exit_d      = exit_q;
    rsp_valid_d = accept && !req_we;
    rsp_rdata_d = '0;

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    // First exit code wins; later done writes are accepted but dropped.
    if (accept && req_we && is_done && !done_q) begin
      done_d = 1'b1;
      exit_d = req_wdata;
    end

    if (accept && !req_we) begin
      if (is_done)       rsp_rdata_d = done_q ? exit_q : '0;
      else if (is_print) rsp_rdata_d = XLEN'(count_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      done_q      <= 1'b0;
      exit_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      done_q      <= done_d;
      exit_q      <= exit_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Storage is not reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= req_wdata[7:0];
  end

endmodule

// File: tb/tb_mmio_console.sv
// Bench for mmio_console: directed scenarios plus random traffic, checked against a
// queue-based model of the console registers and print FIFO.
module tb_mmio_console;

  localparam int          XLEN    = 32;
  localparam int          DEPTH   = 8;
  localparam logic [31:0] DONE_A  = 32'h0000_0100;
  localparam logic [31:0] PRINT_A = 32'h0000_0104;
  localparam logic [31:0] MISS_A  = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        hit, rsp_valid;
  logic [31:0] rsp_rdata;
  logic        char_valid, char_ready;
  logic [7:0]  char_data;
  logic        done;
  logic [31:0] exit_code;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_q[$];
  logic        done_m   = 1'b0;
  logic [31:0] exit_m   = '0;
  logic        rsp_pend = 1'b0;
  logic [31:0] rsp_exp  = '0;

  mmio_console #(
    .XLEN(XLEN), .DONE_ADDR(DONE_A), .PRINT_ADDR(PRINT_A), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .hit(hit), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .char_valid(char_valid), .char_ready(char_ready), .char_data(char_data),
    .done(done), .exit_code(exit_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive after a rising edge, check on the falling edge, update model on the next rise.
  task automatic cyc(input logic v, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] strb, input logic rdy);
    logic        rdy_exp, acc, is_p;
    logic [31:0] rd_val;
    req_valid  = v;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_wstrb  = strb;
    char_ready = rdy;
    @(negedge clk);
    is_p    = (addr == PRINT_A);
    rdy_exp = !(v && we && is_p && exp_q.size() == DEPTH);
    acc     = v && rdy_exp;
    chk("req_ready", {31'b0, req_ready}, {31'b0, rdy_exp});
    chk("hit", {31'b0, hit}, {31'b0, (addr == DONE_A) || is_p});
    chk("char_valid", {31'b0, char_valid}, {31'b0, exp_q.size() != 0});
    if (exp_q.size() != 0) chk("char_data", {24'b0, char_data}, {24'b0, exp_q[0]});
    chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, rsp_pend});
    if (rsp_pend) chk("rsp_rdata", rsp_rdata, rsp_exp);
    chk("done", {31'b0, done}, {31'b0, done_m});
    chk("exit_code", exit_code, exit_m);
    rd_val = '0;
    if (addr == DONE_A)  rd_val = done_m ? exit_m : 32'h0;
    else if (is_p)       rd_val = exp_q.size();
    @(posedge clk);
    if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
    if (acc && we && is_p && strb[0]) exp_q.push_back(wdata[7:0]);
    if (acc && we && addr == DONE_A && !done_m) begin
      done_m = 1'b1;
      exit_m = wdata;
    end
    rsp_pend = acc && !we;
    rsp_exp  = rd_val;
    #1;
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rdy);
  endtask

  initial begin
    logic [31:0] a;
    logic        w;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_wstrb  = '0;
    char_ready = 1'b0;
    #3;
    chk("rst_char_valid", {31'b0, char_valid}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_exit", exit_code, 32'h0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // "Hi" with the sink always ready.
    cyc(1'b1, 1'b1, PRINT_A, 32'h48, 4'hF, 1'b1);
    cyc(1'b1, 1'b1, PRINT_A, 32'h69, 4'hF, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Fill to the brim with the sink stalled, then free one slot.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b1, PRINT_A, 32'h30 + i, 4'h1, 1'b0);
    cyc(1'b1, 1'b1, PRINT_A, 32'h39, 4'h1, 1'b0);
    cyc(1'b1, 1'b0, PRINT_A, 32'h0, 4'h0, 1'b0);
    cyc(1'b1, 1'b1, PRINT_A, 32'h39, 4'h1, 1'b1);
    cyc(1'b1, 1'b1, PRINT_A, 32'h39, 4'h1, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);

    // Byte lane 0 disabled, then an unmatched address.
    cyc(1'b1, 1'b1, PRINT_A, 32'h41, 4'b1110, 1'b1);
    cyc(1'b1, 1'b1, MISS_A, 32'hDEAD_BEEF, 4'hF, 1'b1);
    cyc(1'b1, 1'b0, MISS_A, 32'h0, 4'h0, 1'b1);
    cyc(1'b1, 1'b0, PRINT_A, 32'h0, 4'h0, 1'b1);
    idle(1'b1);

    // Steady push-with-pop stream across several pointer wraps.
    for (int i = 0; i < 24; i++) cyc(1'b1, 1'b1, PRINT_A, $urandom_range(0, 255), 4'hF, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Random mixed traffic; done writes are held back for the directed check.
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0:       a = DONE_A;
        1:       a = PRINT_A;
        2:       a = MISS_A;
        default: a = {$urandom_range(0, 32'h3FF), 2'b00};
      endcase
      w = ($urandom_range(0, 1) == 1) && (a != DONE_A);
      cyc($urandom_range(0, 3) != 0, w, a, $urandom, 4'($urandom_range(0, 15)),
          $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);

    // Exit code capture, first write wins.
    cyc(1'b1, 1'b0, DONE_A, 32'h0, 4'h0, 1'b1);
    cyc(1'b1, 1'b1, DONE_A, 32'h2A, 4'hF, 1'b1);
    cyc(1'b1, 1'b1, DONE_A, 32'h7, 4'hF, 1'b1);
    cyc(1'b1, 1'b0, DONE_A, 32'h0, 4'h0, 1'b1);
    idle(1'b1);

    // FIFO keeps running after done; then reset with bytes queued and a read in flight.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, PRINT_A, 32'h61 + i, 4'h1, 1'b0);
    cyc(1'b1, 1'b0, DONE_A, 32'h0, 4'h0, 1'b0);
    chk("pre_rst_rsp_valid", {31'b0, rsp_valid}, 32'h1);
    chk("pre_rst_char_valid", {31'b0, char_valid}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_char_valid", {31'b0, char_valid}, 32'h0);
    chk("async_done", {31'b0, done}, 32'h0);
    chk("async_exit", exit_code, 32'h0);
    chk("async_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("async_rsp_rdata", rsp_rdata, 32'h0);
    exp_q.delete();
    done_m   = 1'b0;
    exit_m   = '0;
    rsp_pend = 1'b0;
    rsp_exp  = '0;
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, PRINT_A, 32'h0, 4'h0, 1'b1);
    cyc(1'b1, 1'b1, PRINT_A, 32'h5A, 4'h1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_console.md
MMIO_CONSOLE -- requirements
Module: mmio_console

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter XLEN, default 32, the data and address width in bits.
REQ-002 The block SHALL have parameter DONE_ADDR, default 32'h0000_0100, the word address of the done/exit register.
REQ-003 The block SHALL have parameter PRINT_ADDR, default 32'h0000_0104, the word address of the print/status register.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 8, the print FIFO entry count; it must be a power of 2 and at least 2.

Ports (name, direction, width, meaning):
REQ-005 The block SHALL have one clock and an asynchronous active-low reset.
- clk: input, 1 bit, the single clock; all state updates on its rising edge.
- rst_n: input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have these bus ports:
- req_valid: input, 1, request present.
- req_ready: output, 1, request accepted this cycle.
- req_we: input, 1, 1 = write, 0 = read.
- req_addr: input, XLEN, byte address.
- req_wdata: input, XLEN, write data.
- req_wstrb: input, XLEN/8, byte enables.
- hit: output, 1, combinational: req_addr equals DONE_ADDR or PRINT_ADDR.
- rsp_valid: output, 1, read data valid.
- rsp_rdata: output, XLEN, read data.
REQ-007 The block SHALL have these console ports:
- char_valid: output, 1, FIFO head valid.
- char_ready: input, 1, sink accepts head.
- char_data: output, 8, FIFO head byte.
- done: output, 1, sticky completion flag.
- exit_code: output, XLEN, value captured by the first done write.

Function
REQ-008 A request SHALL be accepted only in a cycle where req_valid and req_ready are both 1.
REQ-009 req_ready SHALL be 0 only while req_valid=1, req_we=1, req_addr=PRINT_ADDR, and the registered count equals FIFO_DEPTH; it SHALL be 1 in all other cases and SHALL NOT depend combinationally on char_ready.
REQ-010 An accepted write to PRINT_ADDR with req_wstrb[0]=1 SHALL push req_wdata[7:0]; with req_wstrb[0]=0 it SHALL be accepted and discarded.
REQ-011 An accepted write to DONE_ADDR while done=0 SHALL set done=1 and exit_code=req_wdata on the next edge; writes while done=1 SHALL be accepted and ignored (first code wins).
REQ-012 An accepted read SHALL assert rsp_valid exactly one cycle later, for one cycle, with rsp_rdata registered from the accepted request; back-to-back reads SHALL be supported.
REQ-013 Read of DONE_ADDR SHALL return exit_code when done=1, else 0; read of PRINT_ADDR SHALL return the zero-extended FIFO count sampled at acceptance; read of an unmatched address SHALL still produce rsp_valid with rsp_rdata=0.
REQ-014 An accepted write to an unmatched address SHALL change no state.
REQ-015 The FIFO SHALL pop when char_valid=1 and char_ready=1; char_valid SHALL equal (count != 0), and char_data SHALL be the oldest entry.
REQ-016 The FIFO SHALL have no fall-through: a byte pushed into an empty FIFO SHALL become visible on char_valid on the cycle after the push edge.
REQ-017 A simultaneous push and pop when 0 < count < FIFO_DEPTH SHALL leave count unchanged and preserve order.
REQ-018 When full, a pop in the same cycle SHALL NOT admit a push (REQ-009); the push SHALL be accepted on a later cycle.
REQ-019 The count SHALL be $clog2(FIFO_DEPTH+1) bits wide; read and write pointers SHALL be $clog2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH.
REQ-020 FIFO operation SHALL continue after done=1.

Reset
REQ-021 While rst_n=0, independent of clk: count=0, pointers=0, char_valid=0, done=0, exit_code=0, rsp_valid=0, rsp_rdata=0.
REQ-022 Reset asserted mid-operation SHALL discard all FIFO contents and any pending read response; FIFO data storage need not be reset.
REQ-023 The first edge after rst_n rises SHALL be able to accept a request.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Write 'H' (0x48) then 'i' (0x69) to 0x104 with char_ready=1 -> char_data 0x48 then 0x69 on consecutive cycles; each byte appears one cycle after its push.
- Hold char_ready=0, write 9 bytes with FIFO_DEPTH=8 -> the 9th write stalls (req_ready=0); read 0x104 returns 8; one pop, then the 9th write is accepted the following cycle.
- Write 0x2A to 0x100, then write 0x7 to 0x100 -> done=1, exit_code=0x2A; read 0x100 returns 0x2A.
- Write 0x41 to 0x104 with wstrb=4'b1110 -> count stays 0; write to 0x200 -> hit=0 and no state changes; read 0x200 -> rsp_valid with rdata 0.
- Over 20 or more pushes with simultaneous pops -> pointer wrap with in-order output and no loss.
- Assert rst_n=0 with 3 bytes queued and done=1 -> char_valid=0, done=0, count=0 immediately, without waiting for a clock edge.
